// File: rtl/shreg_cmd_sequencer.sv
// Command sequencer that replays queued {opcode, data, repeat} commands onto a 4-bit shift/add register.
// Optional flush input enabled by defining SHREG_SEQ_ABORT_EN.
module shreg_cmd_sequencer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SHREG_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [DATA_W-1:0]      cmd_data,
    input  logic [CNT_W-1:0]       cmd_rep,
    output logic [2:0]             sel,
    output logic [DATA_W-1:0]      d_in,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 3 + DATA_W + CNT_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ENT_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [2:0]         cur_op_r;
    logic [DATA_W-1:0]  cur_data_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               abort_s;
    logic               push_s;
    logic               pop_s;
    logic               empty_s;
    logic               last_s;
    logic [ENT_W-1:0]   head_s;

`ifdef SHREG_SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign empty_s   = (level_r == LVL_W'(0));
    assign last_s    = (cnt_r == CNT_W'(0));
    assign cmd_ready = (level_r != FULL_LVL) && !abort_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign head_s    = mem_r[rd_ptr_r];

    // Next-state and pop decision; a finished command chains straight into the next queued one.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        if (abort_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (!last_s) begin
                        state_nxt_s = ISSUE;
                    end else if (!empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Current command registers; cleared on entry to IDLE so sel/d_in come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_op_r   <= 3'b000;
            cur_data_r <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            cur_op_r   <= head_s[ENT_W-1 -: 3];
            cur_data_r <= head_s[CNT_W +: DATA_W];
            cnt_r      <= head_s[CNT_W-1:0];
        end else if (state_nxt_s == IDLE) begin
            cur_op_r   <= 3'b000;
            cur_data_r <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else if (!last_s) begin
            cnt_r      <= cnt_r - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_op, cmd_data, cmd_rep};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (abort_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign sel   = cur_op_r;
    assign d_in  = cur_data_r;
    assign level = level_r;
    assign busy  = (state_r == ISSUE) || !empty_s;
    assign done  = (state_r == ISSUE) && last_s && empty_s;

endmodule

// File: tb/tb_shreg_cmd_sequencer.sv
// Self-checking bench for shreg_cmd_sequencer: directed scenarios plus random traffic against a queue model.
// Abort scenario is compiled in when SHREG_SEQ_ABORT_EN is defined.
module tb_shreg_cmd_sequencer;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int LVL_W  = 3;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] rep;
    } cmd_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cmd_rep;
    logic [2:0]        sel;
    logic [DATA_W-1:0] d_in;
    logic              busy;
    logic              done;
    logic [LVL_W-1:0]  level;
`ifdef SHREG_SEQ_ABORT_EN
    logic              abort;
`endif

    shreg_cmd_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SHREG_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_rep   (cmd_rep),
        .sel       (sel),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Downstream accumulator standing in for the register's add opcode.
    logic       acc_clr = 1'b1;
    logic [3:0] acc;
    always @(posedge clk) begin
        if (acc_clr) acc <= 4'h0;
        else if (sel == 3'b110) acc <= acc + d_in;
    end

    // Reference model: queue of pending commands plus the one being issued.
    cmd_t q[$];
    cmd_t cur;
    bit   active = 1'b0;
    int   remaining = 0;
    bit   abort_v = 1'b0;
    bit   last_pushed = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        active = 1'b0;
        remaining = 0;
    endtask

    task automatic check_outputs(input string phase);
        logic [2:0] e_sel;
        logic [3:0] e_d;
        e_sel = active ? cur.op : 3'b000;
        e_d   = active ? cur.data : 4'h0;
        chk({phase, ".sel"},   8'(sel),       8'(e_sel));
        chk({phase, ".d_in"},  8'(d_in),      8'(e_d));
        chk({phase, ".level"}, 8'(level),     8'(q.size()));
        chk({phase, ".ready"}, 8'(cmd_ready), 8'((q.size() < DEPTH) && !abort_v));
        chk({phase, ".busy"},  8'(busy),      8'(active || (q.size() != 0)));
        chk({phase, ".done"},  8'(done),      8'(active && (remaining == 1) && (q.size() == 0)));
    endtask

    task automatic model_step(input bit v, input cmd_t c);
        bit push;
        push = v && (q.size() < DEPTH) && !abort_v;
        last_pushed = push;
        if (abort_v) begin
            q.delete();
            active = 1'b0;
        end else begin
            if (!active || remaining == 1) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    remaining = int'(cur.rep) + 1;
                    active = 1'b1;
                end else begin
                    active = 1'b0;
                end
            end else begin
                remaining--;
            end
            if (push) q.push_back(c);
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input string phase, input bit v, input cmd_t c);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = c.op;
        cmd_data  = c.data;
        cmd_rep   = c.rep;
`ifdef SHREG_SEQ_ABORT_EN
        abort     = abort_v;
`endif
        check_outputs(phase);
        @(posedge clk);
        model_step(v, c);
    endtask

    task automatic drain(input string phase, input int budget);
        cmd_t z;
        int n;
        z = '0;
        n = 0;
        while ((active || q.size() != 0) && n < budget) begin
            cycle(phase, 1'b0, z);
            n++;
        end
        if (n >= budget) chk({phase, ".drain_timeout"}, 8'(q.size()), 8'(0));
        cycle(phase, 1'b0, z);
    endtask

    initial begin
        cmd_t c, z;
        int   n;
        z = '0;
        cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 4'h0; cmd_rep = 4'h0;
`ifdef SHREG_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outputs("reset");
        reset = 1'b0;

        // Single command, rep=0
        cycle("single", 1'b1, '{3'b001, 4'hA, 4'h0});
        drain("single", 10);

        // Repeated add accumulates three times
        @(negedge clk); acc_clr = 1'b0;
        cycle("add", 1'b1, '{3'b110, 4'h3, 4'h2});
        drain("add", 10);
        chk("add.acc", 8'(acc), 8'h09);
        @(negedge clk); acc_clr = 1'b1;

        // Back-to-back chaining with no gap
        cycle("b2b", 1'b1, '{3'b001, 4'h5, 4'h0});
        cycle("b2b", 1'b1, '{3'b010, 4'h8, 4'h1});
        cycle("b2b", 1'b1, '{3'b011, 4'h1, 4'h0});
        drain("b2b", 12);

        // Fill the FIFO behind a long command; sixth push is held until a slot frees
        for (int i = 0; i < 5; i++) cycle("full", 1'b1, '{3'(i + 1), 4'(i), 4'hF});
        c = '{3'b111, 4'hC, 4'h0};
        n = 0;
        last_pushed = 1'b0;
        while (!last_pushed && n < 40) begin
            cycle("full_hold", 1'b1, c);
            n++;
        end
        chk("full.accepted", 8'(last_pushed), 8'(1));
        drain("full", 120);

        // Asynchronous reset mid-issue with three entries queued
        for (int i = 0; i < 4; i++) cycle("rst_fill", 1'b1, '{3'b101, 4'(i + 2), 4'hF});
        cycle("rst_fill", 1'b0, z);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle("rst_after", 1'b0, z);

`ifdef SHREG_SEQ_ABORT_EN
        // Abort during the second of three queued commands
        cycle("abort", 1'b1, '{3'b001, 4'h1, 4'h1});
        cycle("abort", 1'b1, '{3'b010, 4'h2, 4'h3});
        cycle("abort", 1'b1, '{3'b011, 4'h3, 4'h1});
        n = 0;
        while (!(active && cur.op == 3'b010) && n < 10) begin
            cycle("abort_wait", 1'b0, z);
            n++;
        end
        abort_v = 1'b1;
        cycle("abort_hit", 1'b1, '{3'b100, 4'h4, 4'h0});
        abort_v = 1'b0;
        for (int i = 0; i < 4; i++) cycle("abort_after", 1'b0, z);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            c.op   = 3'($urandom_range(0, 7));
            c.data = 4'($urandom_range(0, 15));
            c.rep  = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
            cycle("rand", ($urandom_range(0, 1) == 1), c);
        end
        drain("rand", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
